// File: rtl/ball_track_ctrl_pkg.sv
// ball_track_ctrl_pkg: shared scheduler/tracker state types and grid widths
package ball_track_ctrl_pkg;
    localparam int GRID_X_W = 6;
    localparam int GRID_Y_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SYNC = 2'd1,
        S_RUN  = 2'd2,
        S_SKIP = 2'd3
    } sched_state_t;

    typedef enum logic {
        T_SEARCH = 1'b0,
        T_TRACK  = 1'b1
    } trk_state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction
endpackage

// File: rtl/ball_track_ctrl_track_filter.sv
// track_filter: per-frame hit gate plus SEARCH/TRACK update with velocity and coast prediction
module track_filter
    import ball_track_ctrl_pkg::*;
#(
    parameter int COLS        = 40,
    parameter int ROWS        = 30,
    parameter int CNT_W       = 12,
    parameter int MIN_COUNT   = 8,
    parameter int MAX_JUMP    = 4,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 5
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       clr,
    input  logic                       eval,
    input  logic                       seen,
    input  logic [GRID_X_W-1:0]        det_x,
    input  logic [GRID_Y_W-1:0]        det_y,
    input  logic [CNT_W-1:0]           det_cnt,
    output logic                       track_valid,
    output logic [GRID_X_W-1:0]        track_x,
    output logic [GRID_Y_W-1:0]        track_y,
    output logic signed [GRID_X_W:0]   vel_x,
    output logic signed [GRID_Y_W:0]   vel_y,
    output logic                       lost
);
    localparam logic [GRID_X_W:0] JMP_X = (GRID_X_W+1)'(MAX_JUMP);
    localparam logic [GRID_Y_W:0] JMP_Y = (GRID_Y_W+1)'(MAX_JUMP);
    localparam logic signed [GRID_X_W+1:0] MAX_X = (GRID_X_W+2)'(COLS-1);
    localparam logic signed [GRID_Y_W+1:0] MAX_Y = (GRID_Y_W+2)'(ROWS-1);

    trk_state_t st, st_n;
    logic [3:0] acq, acq_n, miss, miss_n, acq_inc, miss_inc;
    logic [GRID_X_W-1:0] tx_n, sat_x;
    logic [GRID_Y_W-1:0] ty_n, sat_y;
    logic signed [GRID_X_W:0] vx_n, dx, adx;
    logic signed [GRID_Y_W:0] vy_n, dy, ady;
    logic signed [GRID_X_W+1:0] sx;
    logic signed [GRID_Y_W+1:0] sy;
    logic valid_n, lost_n, near, hit;

    assign dx = $signed({1'b0, det_x}) - $signed({1'b0, track_x});
    assign dy = $signed({1'b0, det_y}) - $signed({1'b0, track_y});
    assign adx = dx[GRID_X_W] ? -dx : dx;
    assign ady = dy[GRID_Y_W] ? -dy : dy;
    assign near = ($unsigned(adx) <= JMP_X) && ($unsigned(ady) <= JMP_Y);
    assign hit = seen && (det_cnt >= CNT_W'(MIN_COUNT)) && (st == T_SEARCH || near);
    assign acq_inc = sat_inc(acq);
    assign miss_inc = sat_inc(miss);
    // Coast prediction is clamped to the grid instead of wrapping
    assign sx = $signed({2'b00, track_x}) + $signed({vel_x[GRID_X_W], vel_x});
    assign sy = $signed({2'b00, track_y}) + $signed({vel_y[GRID_Y_W], vel_y});
    assign sat_x = sx[GRID_X_W+1] ? '0 : (sx > MAX_X) ? MAX_X[GRID_X_W-1:0] : sx[GRID_X_W-1:0];
    assign sat_y = sy[GRID_Y_W+1] ? '0 : (sy > MAX_Y) ? MAX_Y[GRID_Y_W-1:0] : sy[GRID_Y_W-1:0];

    always_comb begin
        st_n = st;
        acq_n = acq;
        miss_n = miss;
        tx_n = track_x;
        ty_n = track_y;
        vx_n = vel_x;
        vy_n = vel_y;
        valid_n = track_valid;
        lost_n = 1'b0;
        if (clr) begin
            st_n = T_SEARCH;
            acq_n = '0;
            miss_n = '0;
            tx_n = '0;
            ty_n = '0;
            vx_n = '0;
            vy_n = '0;
            valid_n = 1'b0;
        end else if (eval && st == T_SEARCH) begin
            acq_n = hit ? acq_inc : '0;
            tx_n = hit ? det_x : track_x;
            ty_n = hit ? det_y : track_y;
            if (hit && acq_inc >= 4'(ACQ_FRAMES)) begin
                st_n = T_TRACK;
                valid_n = 1'b1;
                vx_n = '0;
                vy_n = '0;
                miss_n = '0;
            end
        end else if (eval && hit) begin
            vx_n = dx;
            vy_n = dy;
            tx_n = det_x;
            ty_n = det_y;
            miss_n = '0;
        end else if (eval) begin
            miss_n = miss_inc;
            tx_n = sat_x;
            ty_n = sat_y;
            if (miss_inc >= 4'(LOST_FRAMES)) begin
                st_n = T_SEARCH;
                valid_n = 1'b0;
                vx_n = '0;
                vy_n = '0;
                acq_n = '0;
                lost_n = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            st <= T_SEARCH;
            acq <= '0;
            miss <= '0;
            track_x <= '0;
            track_y <= '0;
            vel_x <= '0;
            vel_y <= '0;
            track_valid <= 1'b0;
            lost <= 1'b0;
        end else begin
            st <= st_n;
            acq <= acq_n;
            miss <= miss_n;
            track_x <= tx_n;
            track_y <= ty_n;
            vel_x <= vx_n;
            vel_y <= vy_n;
            track_valid <= valid_n;
            lost <= lost_n;
        end
    end
endmodule

// File: rtl/ball_track_ctrl.sv
// ball_track_ctrl: frame scheduler for the ball detector; latches each frame's result and feeds the tracker
module ball_track_ctrl
    import ball_track_ctrl_pkg::*;
#(
    parameter int COLS        = 40,
    parameter int ROWS        = 30,
    parameter int CNT_W       = 12,
    parameter int MIN_COUNT   = 8,
    parameter int MAX_JUMP    = 4,
    parameter int ACQ_FRAMES  = 3,
    parameter int LOST_FRAMES = 5,
    parameter int SKIP_FRAMES = 0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 MODE_EN,
    input  logic                 VGA_VS,
    input  logic                 DET_VALID,
    input  logic [5:0]           DET_X,
    input  logic [4:0]           DET_Y,
    input  logic [CNT_W-1:0]     DET_COUNT,
    output logic                 DET_ENABLE,
    output logic                 TRACK_VALID,
    output logic [5:0]           TRACK_X,
    output logic [4:0]           TRACK_Y,
    output logic [6:0]           VEL_X,
    output logic [5:0]           VEL_Y,
    output logic                 LOST,
    output logic [1:0]           STATE
);
    sched_state_t state, state_n;
    logic [3:0] skip_cnt, skip_n;
    logic vs_q, fb, sel, seen, eval;
    logic [GRID_X_W-1:0] lat_x;
    logic [GRID_Y_W-1:0] lat_y;
    logic [CNT_W-1:0] lat_cnt;
    logic signed [GRID_X_W:0] vx;
    logic signed [GRID_Y_W:0] vy;

    assign fb = vs_q & ~VGA_VS;
    assign sel = DET_VALID && state == S_RUN;
    assign eval = MODE_EN && state == S_RUN && fb;
    assign STATE = state;
    assign VEL_X = vx;
    assign VEL_Y = vy;

    always_comb begin
        state_n = state;
        skip_n = skip_cnt;
        if (!MODE_EN) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_n = S_SYNC;
                S_SYNC: state_n = fb ? S_RUN : S_SYNC;
                S_RUN: if (fb && SKIP_FRAMES != 0) begin
                    state_n = S_SKIP;
                    skip_n = 4'(SKIP_FRAMES);
                end
                S_SKIP: if (fb) begin
                    state_n = (skip_cnt <= 4'd1) ? S_RUN : S_SKIP;
                    skip_n = skip_cnt - 4'd1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            vs_q <= 1'b1;
            state <= S_IDLE;
            skip_cnt <= '0;
            seen <= 1'b0;
            lat_x <= '0;
            lat_y <= '0;
            lat_cnt <= '0;
            DET_ENABLE <= 1'b0;
        end else begin
            vs_q <= VGA_VS;
            state <= state_n;
            skip_cnt <= skip_n;
            seen <= MODE_EN && state == S_RUN && !fb && (seen || DET_VALID);
            if (sel) begin
                lat_x <= DET_X;
                lat_y <= DET_Y;
                lat_cnt <= DET_COUNT;
            end
            DET_ENABLE <= state == S_RUN && state_n == S_RUN;
        end
    end

    // A pulse arriving on the boundary cycle still belongs to the frame being closed
    track_filter #(
        .COLS(COLS), .ROWS(ROWS), .CNT_W(CNT_W), .MIN_COUNT(MIN_COUNT),
        .MAX_JUMP(MAX_JUMP), .ACQ_FRAMES(ACQ_FRAMES), .LOST_FRAMES(LOST_FRAMES)
    ) u_filter (
        .CLK(CLK),
        .RST_N(RST_N),
        .clr(!MODE_EN),
        .eval(eval),
        .seen(seen || sel),
        .det_x(sel ? DET_X : lat_x),
        .det_y(sel ? DET_Y : lat_y),
        .det_cnt(sel ? DET_COUNT : lat_cnt),
        .track_valid(TRACK_VALID),
        .track_x(TRACK_X),
        .track_y(TRACK_Y),
        .vel_x(vx),
        .vel_y(vy),
        .lost(LOST)
    );
endmodule

// File: tb/tb_ball_track_ctrl.sv
// tb_ball_track_ctrl: directed frame vectors for the ball tracker, plus skip-decimation and mode-off sequences
module tb_ball_track_ctrl;
    logic CLK = 1'b0, RST_N, MODE_EN, VGA_VS, DET_VALID;
    logic [5:0] DET_X;
    logic [4:0] DET_Y;
    logic [11:0] DET_COUNT;
    logic DET_ENABLE, TRACK_VALID, LOST;
    logic [5:0] TRACK_X;
    logic [4:0] TRACK_Y;
    logic [6:0] VEL_X;
    logic [5:0] VEL_Y;
    logic [1:0] STATE;
    logic en2, valid2, lost2;
    logic [5:0] tx2;
    logic [4:0] ty2;
    logic [6:0] vx2;
    logic [5:0] vy2;
    logic [1:0] state2;
    int n_vec = 0, n_bad = 0;
    logic lost_a, lost_b, mid_en, mid_en2;

    always #5 CLK = ~CLK;

    ball_track_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .MODE_EN(MODE_EN), .VGA_VS(VGA_VS),
        .DET_VALID(DET_VALID), .DET_X(DET_X), .DET_Y(DET_Y), .DET_COUNT(DET_COUNT),
        .DET_ENABLE(DET_ENABLE), .TRACK_VALID(TRACK_VALID), .TRACK_X(TRACK_X),
        .TRACK_Y(TRACK_Y), .VEL_X(VEL_X), .VEL_Y(VEL_Y), .LOST(LOST), .STATE(STATE)
    );

    ball_track_ctrl #(.SKIP_FRAMES(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .MODE_EN(MODE_EN), .VGA_VS(VGA_VS),
        .DET_VALID(DET_VALID), .DET_X(DET_X), .DET_Y(DET_Y), .DET_COUNT(DET_COUNT),
        .DET_ENABLE(en2), .TRACK_VALID(valid2), .TRACK_X(tx2),
        .TRACK_Y(ty2), .VEL_X(vx2), .VEL_Y(vy2), .LOST(lost2), .STATE(state2)
    );

    typedef struct {
        logic dv;
        logic [5:0] x;
        logic [4:0] y;
        logic [11:0] cnt;
        logic e_valid;
        logic [5:0] e_x;
        logic [4:0] e_y;
        logic signed [6:0] e_vx;
        logic signed [5:0] e_vy;
        logic e_lost;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One frame: VS high with an optional mid-frame (or boundary-cycle) DET_VALID, then a 2-cycle VS low
    task automatic frame(input logic dv, input logic late, input logic [5:0] x,
                         input logic [4:0] y, input logic [11:0] c);
        VGA_VS = 1'b1;
        DET_X = x;
        DET_Y = y;
        DET_COUNT = c;
        repeat (5) @(negedge CLK);
        DET_VALID = dv & ~late;
        mid_en = DET_ENABLE;
        mid_en2 = en2;
        @(negedge CLK);
        DET_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        VGA_VS = 1'b0;
        DET_VALID = dv & late;
        @(negedge CLK);
        DET_VALID = 1'b0;
        lost_a = LOST;
        @(negedge CLK);
        lost_b = LOST;
    endtask

    task automatic add(input logic dv, input logic [5:0] x, input logic [4:0] y, input logic [11:0] c,
                       input logic ev, input logic [5:0] ex, input logic [4:0] ey,
                       input int evx, input int evy, input logic el);
        vec_t v;
        v.dv = dv; v.x = x; v.y = y; v.cnt = c;
        v.e_valid = ev; v.e_x = ex; v.e_y = ey;
        v.e_vx = 7'(evx); v.e_vy = 6'(evy); v.e_lost = el;
        tv.push_back(v);
    endtask

    initial begin
        // acquire
        add(1, 10, 5, 20, 0, 10, 5, 0, 0, 0);
        add(1, 10, 5, 20, 0, 10, 5, 0, 0, 0);
        add(1, 10, 5, 20, 1, 10, 5, 0, 0, 0);
        // velocity, then a jump that is gated out and coasted
        add(1, 12, 6, 20, 1, 12, 6, 2, 1, 0);
        add(1, 14, 7, 20, 1, 14, 7, 2, 1, 0);
        add(1, 30, 7, 20, 1, 16, 8, 2, 1, 0);
        add(1, 20, 8, 20, 1, 20, 8, 4, 0, 0);
        add(1, 24, 8, 20, 1, 24, 8, 4, 0, 0);
        add(1, 28, 8, 20, 1, 28, 8, 4, 0, 0);
        add(1, 32, 8, 20, 1, 32, 8, 4, 0, 0);
        add(1, 34, 8, 20, 1, 34, 8, 2, 0, 0);
        add(1, 36, 8, 20, 1, 36, 8, 2, 0, 0);
        // coast to the right edge, then drop
        add(0, 0, 0, 0, 1, 38, 8, 2, 0, 0);
        add(0, 0, 0, 0, 1, 39, 8, 2, 0, 0);
        add(0, 0, 0, 0, 1, 39, 8, 2, 0, 0);
        add(0, 0, 0, 0, 1, 39, 8, 2, 0, 0);
        add(0, 0, 0, 0, 0, 39, 8, 0, 0, 1);
        // count one below threshold never acquires
        add(1, 10, 5, 7, 0, 39, 8, 0, 0, 0);
        add(1, 10, 5, 7, 0, 39, 8, 0, 0, 0);
        add(1, 10, 5, 7, 0, 39, 8, 0, 0, 0);
        add(1, 10, 5, 7, 0, 39, 8, 0, 0, 0);
        // count exactly at threshold acquires
        add(1, 10, 5, 8, 0, 10, 5, 0, 0, 0);
        add(1, 10, 5, 8, 0, 10, 5, 0, 0, 0);
        add(1, 10, 5, 8, 1, 10, 5, 0, 0, 0);
        // jump of exactly MAX_JUMP accepted, one more rejected; coast clamps at row 0
        add(1, 14, 1, 20, 1, 14, 1, 4, -4, 0);
        add(1, 19, 1, 20, 1, 18, 0, 4, -4, 0);

        RST_N = 1'b0; MODE_EN = 1'b0; VGA_VS = 1'b1; DET_VALID = 1'b0;
        DET_X = '0; DET_Y = '0; DET_COUNT = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {DET_ENABLE, TRACK_VALID, TRACK_X, TRACK_Y, VEL_X, VEL_Y, LOST, STATE},
            40'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        MODE_EN = 1'b1;
        @(negedge CLK);
        chk("sync_state", {DET_ENABLE, STATE}, {1'b0, 2'd1});
        repeat (3) @(negedge CLK);
        chk("sync_hold", {DET_ENABLE, STATE}, {1'b0, 2'd1});
        VGA_VS = 1'b0;
        @(negedge CLK);
        chk("run_entry", {DET_ENABLE, STATE}, {1'b0, 2'd2});
        @(negedge CLK);
        chk("enable_rise", {DET_ENABLE, STATE}, {1'b1, 2'd2});

        for (int i = 0; i < tv.size(); i++) begin
            frame(tv[i].dv, 1'b0, tv[i].x, tv[i].y, tv[i].cnt);
            chk($sformatf("vec%0d", i),
                {TRACK_VALID, TRACK_X, TRACK_Y, VEL_X, VEL_Y, lost_a, lost_b, DET_ENABLE},
                {tv[i].e_valid, tv[i].e_x, tv[i].e_y, tv[i].e_vx, tv[i].e_vy, tv[i].e_lost, 1'b0, 1'b1});
        end

        // DET_VALID on the boundary cycle closes the ending frame
        frame(1'b1, 1'b1, 6'd20, 5'd2, 12'd20);
        chk("coincident_fb", {TRACK_VALID, TRACK_X, TRACK_Y, VEL_X, VEL_Y},
            {1'b1, 6'd20, 5'd2, 7'd2, 6'd2});

        // tracking mode switched off mid-frame
        VGA_VS = 1'b1;
        repeat (3) @(negedge CLK);
        MODE_EN = 1'b0;
        @(negedge CLK);
        chk("mode_off", {STATE, DET_ENABLE, TRACK_VALID, LOST}, {2'd0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge CLK);
        chk("mode_off_quiet", {STATE, DET_ENABLE, TRACK_VALID, LOST, valid2}, 40'd0);

        // decimated instance: enable pattern 1,0,0,1 and skip-frame hits ignored
        MODE_EN = 1'b1;
        @(negedge CLK);
        VGA_VS = 1'b0;
        repeat (2) @(negedge CLK);
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        chk("skip_en_f0", {mid_en2, mid_en}, 2'b11);
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        chk("skip_en_f1", {mid_en2, state2}, {1'b0, 2'd3});
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        chk("skip_en_f2", {mid_en2, valid2}, 2'b00);
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        chk("skip_en_f3", {mid_en2, valid2, mid_en, TRACK_VALID}, 4'b1011);
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        chk("skip_still_search", {mid_en2, valid2}, 2'b00);
        frame(1'b1, 1'b0, 6'd10, 5'd5, 12'd20);
        chk("skip_acquire", {mid_en2, valid2, tx2, ty2}, {1'b1, 1'b1, 6'd10, 5'd5});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
